snes_multi_reader: RTL and testbench
====================================

Name: snes_multi_reader

Overview:
- Parametrised successor to the single-pad SNES reader.
- Polls NUM_CTRL SNES/NES pads over one shared LATCH/PULSE pair, with a separate DATA line per pad.
- Bit count, timing and poll rate are generics.
- Per pad it provides registered active-high button state, one-cycle pressed/released event masks and a frame-valid strobe for the NIOS PIO/LED glue at top level.

Parameters:
- NUM_CTRL, 2, number of pads sharing LATCH/PULSE (1..4).
- NUM_BITS, 16, bits shifted per frame (SNES 16, NES 8; legal range 1..32).
- LATCH_CYCLES, 600, LATCH high time in CLOCK cycles (12 us at 50 MHz).
- HALF_CYCLES, 300, PULSE half period (6 us); must be at least 4.
- POLL_CYCLES, 833333, frame-start to frame-start period (60 Hz).

Ports:
- CLOCK  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- ENABLE  in  1  allow periodic polling.
- POLL_NOW  in  1  one-cycle request to start a frame immediately.
- DATA  in  NUM_CTRL  serial data per pad, active-low button, asynchronous.
- LATCH  out  1  shared latch to pads, active-high.
- PULSE  out  1  shared shift clock to pads, idle low.
- BUTTONS  out  NUM_CTRL*NUM_BITS  pad k occupies [k*NUM_BITS +: NUM_BITS]; bit 0 is the first bit shifted; 1 = pressed.
- PRESSED  out  NUM_CTRL*NUM_BITS  one-cycle mask of 0->1 transitions.
- RELEASED  out  NUM_CTRL*NUM_BITS  one-cycle mask of 1->0 transitions.
- VALID  out  1  one-cycle strobe when BUTTONS updates.
- BUSY  out  1  high while a frame is in progress.

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0; state IDLE; counters 0; shift registers 0; synchronisers 0.
- Input path:
  - Each DATA bit passes a 2-flop synchroniser, then is inverted.
  - All sampling uses the synchronised value.
- State machine IDLE -> LATCH -> WAIT0 -> (HIGH <-> LOW) -> DONE -> IDLE:
  - IDLE: LATCH=0, PULSE=0.
    - Go to LATCH when POLL_NOW=1, or when ENABLE=1 and poll_cnt has reached POLL_CYCLES-1.
    - poll_cnt counts every cycle, saturates at POLL_CYCLES-1 and clears on frame start.
  - LATCH: LATCH=1 for exactly LATCH_CYCLES cycles.
  - WAIT0: LATCH=0, PULSE=0 for HALF_CYCLES cycles. On the last cycle, sample bit 0 into every shift register; bit_idx=1.
    - If NUM_BITS=1, go to DONE.
  - HIGH: PULSE=1 for HALF_CYCLES cycles, then go to LOW.
  - LOW: PULSE=0 for HALF_CYCLES cycles. On the last cycle, sample bit bit_idx.
    - If bit_idx=NUM_BITS-1, go to DONE; otherwise increment bit_idx and go to HIGH.
  - DONE (1 cycle): BUTTONS<=shift; PRESSED<=shift&~BUTTONS; RELEASED<=~shift&BUTTONS; VALID<=1. Go to IDLE.
- Frame length is LATCH_CYCLES + HALF_CYCLES*(2*NUM_BITS-1) + 1 cycles (9901 at defaults).
  - If this exceeds POLL_CYCLES, the next frame starts on the first IDLE cycle.
- PRESSED, RELEASED and VALID are 0 in every cycle other than the cycle after DONE.
- BUSY=1 in all states except IDLE.
- POLL_NOW or ENABLE changes during a frame are ignored; ENABLE is evaluated only in IDLE. A frame in progress always completes.
- POLL_NOW and a periodic expiry in the same IDLE cycle start one frame only.
- The first frame after reset reports PRESSED for every held button, because the previous state is 0.
- Counters are sized with $clog2 of their maximum value. No wrap: every counter clears on state entry.

Decomposition:
- Package snes_pkg:
  - state enum {IDLE, LATCH, WAIT0, HIGH, LOW, DONE};
  - default timing constants;
  - SNES bit indices: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
- Sub-module snes_shift_channel, one per pad via generate:
  - synchroniser, NUM_BITS shift register, BUTTONS/PRESSED/RELEASED registers;
  - driven by sample_en, bit_idx and commit strobes from the top FSM.

Test Plan:
Bench parameters: NUM_CTRL=2, NUM_BITS=16, LATCH_CYCLES=8, HALF_CYCLES=4, POLL_CYCLES=200.
- Reset then ENABLE=1:
  - LATCH rises at cycle 199 and stays high for 8 cycles;
  - 15 PULSE highs of 4 cycles each;
  - VALID once, 8+4*31+1=133 cycles after LATCH rises;
  - next LATCH 200 cycles after the previous one.
- Pad models present pad0 bits 0x0F0F and pad1 bits 0x0001 (button bits, DATA driven low for set bits):
  - BUTTONS={16'h0001,16'hF0F0}? No — expected BUTTONS[15:0]=16'h0F0F and BUTTONS[31:16]=16'h0001;
  - PRESSED equals BUTTONS in the VALID cycle, and is 0 the next cycle.
- Second frame with pad0=0x0F0E: RELEASED[0]=1 and all other event bits 0; PRESSED=0.
- ENABLE=0 with POLL_NOW pulsed in IDLE: exactly one frame, then no LATCH for 1000 cycles. POLL_NOW pulsed during a frame: no extra frame.
- reset_n asserted during HIGH: LATCH, PULSE, BUSY and BUTTONS go 0 immediately. After release, the FSM waits a full POLL_CYCLES.
- NUM_BITS=8, NUM_CTRL=1 build: 7 PULSE highs; VALID 8+4*15+1=69 cycles after LATCH rises.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared types and constants for the multi-pad SNES/NES controller reader.
package snes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WAIT0,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

  localparam int DEF_NUM_CTRL     = 2;
  localparam int DEF_NUM_BITS     = 16;
  localparam int DEF_LATCH_CYCLES = 600;     // 12 us at 50 MHz
  localparam int DEF_HALF_CYCLES  = 300;     // 6 us
  localparam int DEF_POLL_CYCLES  = 833333;  // 60 Hz

  // Button positions within one pad's BUTTONS slice (bit 0 is shifted first).
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/snes_shift_channel.sv
// One pad: DATA synchroniser, frame shift register and the committed
// button / pressed / released registers.
module snes_shift_channel
  import snes_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_in,
  input  logic                sample_en,
  input  logic [IDX_W-1:0]    bit_idx,
  input  logic                commit,
  output logic [NUM_BITS-1:0] buttons,
  output logic [NUM_BITS-1:0] pressed,
  output logic [NUM_BITS-1:0] released
);

  logic                sync1_q, sync2_q;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic [NUM_BITS-1:0] pressed_q, pressed_d;
  logic [NUM_BITS-1:0] released_q, released_d;

  always_comb begin
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    // Pad drives low for a pressed button, so invert after synchronising.
    if (sample_en) shift_d[bit_idx] = ~sync2_q;
    if (commit) begin
      buttons_d  = shift_q;
      pressed_d  = shift_q & ~buttons_q;
      released_d = ~shift_q & buttons_q;
    end
  end

  // NOTE: the shift register is reset along with the control flops because
  // the first frame's PRESSED mask is defined against an all-zero history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep sync1_q -> sync2_q a true
      // two-stage pipeline regardless of statement order.
      sync1_q    <= data_in;
      sync2_q    <= sync1_q;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign buttons  = buttons_q;
  assign pressed  = pressed_q;
  assign released = released_q;

endmodule

// File: rtl/snes_multi_reader.sv
// Polls NUM_CTRL SNES/NES pads over a shared LATCH/PULSE pair and reports
// per-pad button state plus one-cycle press/release event masks.
module snes_multi_reader
  import snes_pkg::*;
#(
  parameter int NUM_CTRL     = DEF_NUM_CTRL,
  parameter int NUM_BITS     = DEF_NUM_BITS,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int POLL_CYCLES  = DEF_POLL_CYCLES
) (
  input  logic                         CLOCK,
  input  logic                         reset_n,
  input  logic                         ENABLE,
  input  logic                         POLL_NOW,
  input  logic [NUM_CTRL-1:0]          DATA,
  output logic                         LATCH,
  output logic                         PULSE,
  output logic [NUM_CTRL*NUM_BITS-1:0] BUTTONS,
  output logic [NUM_CTRL*NUM_BITS-1:0] PRESSED,
  output logic [NUM_CTRL*NUM_BITS-1:0] RELEASED,
  output logic                         VALID,
  output logic                         BUSY
);

  localparam int TMR_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES - 1 : HALF_CYCLES - 1;
  localparam int TMR_W   = cnt_width(TMR_MAX);
  localparam int POLL_W  = cnt_width(POLL_CYCLES - 1);
  localparam int IDX_W   = cnt_width(NUM_BITS - 1);

  localparam logic [TMR_W-1:0]  LATCH_LAST = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  HALF_LAST  = TMR_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST   = IDX_W'(NUM_BITS - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              latch_q, pulse_q, busy_q, valid_q;
  logic              sample_en, commit;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    tmr_d     = '0;
    bit_idx_d = bit_idx_q;
    poll_d    = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;
    sample_en = 1'b0;
    commit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous POLL_NOW and expiry still yields a single frame.
        if (POLL_NOW || (ENABLE && poll_q == POLL_LAST)) begin
          state_d   = ST_LATCH;
          bit_idx_d = '0;
          poll_d    = '0;
        end
      end
      ST_LATCH: begin
        if (tmr_q == LATCH_LAST) state_d = ST_WAIT0;
        else                     tmr_d   = tmr_q + 1'b1;
      end
      ST_WAIT0: begin
        if (tmr_q == HALF_LAST) begin
          sample_en = 1'b1;
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = (NUM_BITS == 1) ? ST_DONE : ST_HIGH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (tmr_q == HALF_LAST) state_d = ST_LOW;
        else                    tmr_d   = tmr_q + 1'b1;
      end
      ST_LOW: begin
        if (tmr_q == HALF_LAST) begin
          sample_en = 1'b1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = ST_HIGH;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad-facing strobes are registered from the next state so they are
  // glitch-free and aligned with state_q.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      poll_q    <= '0;
      bit_idx_q <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      poll_q    <= poll_d;
      bit_idx_q <= bit_idx_d;
      latch_q   <= (state_d == ST_LATCH);
      pulse_q   <= (state_d == ST_HIGH);
      busy_q    <= (state_d != ST_IDLE);
      valid_q   <= commit;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_pad
    snes_shift_channel #(
      .NUM_BITS (NUM_BITS),
      .IDX_W    (IDX_W)
    ) u_channel (
      .clk       (CLOCK),
      .rst_n     (reset_n),
      .data_in   (DATA[g]),
      .sample_en (sample_en),
      .bit_idx   (bit_idx_q),
      .commit    (commit),
      .buttons   (BUTTONS[g*NUM_BITS +: NUM_BITS]),
      .pressed   (PRESSED[g*NUM_BITS +: NUM_BITS]),
      .released  (RELEASED[g*NUM_BITS +: NUM_BITS])
    );
  end

  assign LATCH = latch_q;
  assign PULSE = pulse_q;
  assign BUSY  = busy_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_snes_multi_reader.sv
// Directed bench: a 2-pad/16-bit reader and a 1-pad/8-bit reader driven by
// behavioural pad models, with frame timing and event masks checked.
module tb_snes_multi_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_a = 1'b0, poll_a = 1'b0;
  logic       enable_b = 1'b0, poll_b = 1'b0;
  logic [1:0] data_a;
  logic [0:0] data_b;
  logic       latch_a, pulse_a, valid_a, busy_a;
  logic       latch_b, pulse_b, valid_b, busy_b;
  logic [31:0] buttons_a, pressed_a, released_a;
  logic [7:0]  buttons_b, pressed_b, released_b;

  logic [15:0] pad0 = 16'h0F0F;
  logic [15:0] pad1 = 16'h0001;
  logic [7:0]  padb = 8'hA5;
  int idx_a = 0;
  int idx_b = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snes_multi_reader #(
    .NUM_CTRL(2), .NUM_BITS(16), .LATCH_CYCLES(8), .HALF_CYCLES(4), .POLL_CYCLES(200)
  ) u_dut_a (
    .CLOCK(clk), .reset_n(rst_n), .ENABLE(enable_a), .POLL_NOW(poll_a), .DATA(data_a),
    .LATCH(latch_a), .PULSE(pulse_a), .BUTTONS(buttons_a), .PRESSED(pressed_a),
    .RELEASED(released_a), .VALID(valid_a), .BUSY(busy_a)
  );

  snes_multi_reader #(
    .NUM_CTRL(1), .NUM_BITS(8), .LATCH_CYCLES(8), .HALF_CYCLES(4), .POLL_CYCLES(200)
  ) u_dut_b (
    .CLOCK(clk), .reset_n(rst_n), .ENABLE(enable_b), .POLL_NOW(poll_b), .DATA(data_b),
    .LATCH(latch_b), .PULSE(pulse_b), .BUTTONS(buttons_b), .PRESSED(pressed_b),
    .RELEASED(released_b), .VALID(valid_b), .BUSY(busy_b)
  );

  // Pad models: LATCH reloads bit 0, each PULSE rise advances; idle line is high.
  always @(posedge latch_a or posedge pulse_a) begin
    if (latch_a) idx_a = 0;
    else         idx_a = idx_a + 1;
  end
  always @(posedge latch_b or posedge pulse_b) begin
    if (latch_b) idx_b = 0;
    else         idx_b = idx_b + 1;
  end
  assign data_a[0] = (idx_a < 16) ? ~pad0[idx_a[3:0]] : 1'b1;
  assign data_a[1] = (idx_a < 16) ? ~pad1[idx_a[3:0]] : 1'b1;
  assign data_b[0] = (idx_b < 8)  ? ~padb[idx_b[2:0]] : 1'b1;

  logic        mon_sel = 1'b0;
  logic        mon_latch, mon_pulse, mon_valid;
  logic [31:0] mon_buttons, mon_pressed, mon_released;
  assign mon_latch    = mon_sel ? latch_b : latch_a;
  assign mon_pulse    = mon_sel ? pulse_b : pulse_a;
  assign mon_valid    = mon_sel ? valid_b : valid_a;
  assign mon_buttons  = mon_sel ? {24'b0, buttons_b}  : buttons_a;
  assign mon_pressed  = mon_sel ? {24'b0, pressed_b}  : pressed_a;
  assign mon_released = mon_sel ? {24'b0, released_b} : released_a;

  typedef struct {
    int          latch_len;
    int          pulse_rises;
    int          pulse_high;
    int          valid_at;
    int          valid_cnt;
    logic [31:0] buttons;
    logic [31:0] pressed;
    logic [31:0] released;
    logic [31:0] after_events;
    int          next_latch_at;
  } frame_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call with LATCH just seen high; follows the frame until the next LATCH
  // rise or until limit cycles pass.
  task automatic measure(input int limit, output frame_t f);
    logic prev_latch, prev_pulse;
    bit   in_latch;
    f = '{default: 0};
    f.latch_len = 1;
    in_latch    = 1'b1;
    prev_latch  = 1'b1;
    prev_pulse  = mon_pulse;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (mon_latch && !prev_latch) begin
        f.next_latch_at = i;
        break;
      end
      if (mon_latch && in_latch) f.latch_len++;
      else                       in_latch = 1'b0;
      if (mon_pulse && !prev_pulse) f.pulse_rises++;
      if (mon_pulse) f.pulse_high++;
      if (f.valid_cnt == 1 && i == f.valid_at + 1)
        f.after_events = mon_pressed | mon_released | {31'b0, mon_valid};
      if (mon_valid) begin
        f.valid_cnt++;
        if (f.valid_cnt == 1) begin
          f.valid_at = i;
          f.buttons  = mon_buttons;
          f.pressed  = mon_pressed;
          f.released = mon_released;
        end
      end
      prev_latch = mon_latch;
      prev_pulse = mon_pulse;
    end
  endtask

  task automatic cycles_to_latch(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (latch_a) begin
        n = i;
        break;
      end
    end
  endtask

  frame_t f;
  int     n, rises, valids;
  logic   prev;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_latch",   {31'b0, latch_a}, 32'd0);
    check("rst_pulse",   {31'b0, pulse_a}, 32'd0);
    check("rst_busy",    {31'b0, busy_a},  32'd0);
    check("rst_valid",   {31'b0, valid_a}, 32'd0);
    check("rst_buttons", buttons_a,        32'd0);

    // Periodic polling: poll counter hits 199 in the 200th cycle after release.
    rst_n    = 1'b1;
    enable_a = 1'b1;
    cycles_to_latch(400, n);
    check("first_latch_delay", n, 200);

    measure(300, f);
    check("f1_latch_len",   f.latch_len,     8);
    check("f1_pulse_rises", f.pulse_rises,   15);
    check("f1_pulse_high",  f.pulse_high,    60);
    check("f1_valid_at",    f.valid_at,      133);
    check("f1_valid_cnt",   f.valid_cnt,     1);
    check("f1_buttons",     f.buttons,       32'h0001_0F0F);
    check("f1_pressed",     f.pressed,       32'h0001_0F0F);
    check("f1_released",    f.released,      32'h0);
    check("f1_after",       f.after_events,  32'h0);
    check("f1_period",      f.next_latch_at, 200);

    // Frame 2 started; release pad0 button B before bit 0 is sampled.
    pad0 = 16'h0F0E;
    measure(300, f);
    check("f2_valid_at",  f.valid_at,      133);
    check("f2_buttons",   f.buttons,       32'h0001_0F0E);
    check("f2_pressed",   f.pressed,       32'h0);
    check("f2_released",  f.released,      32'h0000_0001);
    check("f2_after",     f.after_events,  32'h0);
    check("f2_period",    f.next_latch_at, 200);

    // Manual polling: one frame per POLL_NOW, mid-frame POLL_NOW ignored.
    enable_a = 1'b0;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (!busy_a) begin
        n = i;
        break;
      end
    end
    check("idle_reached", {31'b0, (n > 0)}, 32'd1);
    poll_a = 1'b1;
    tick();
    poll_a = 1'b0;
    check("poll_now_latch", {31'b0, latch_a}, 32'd1);
    rises  = 0;
    valids = 0;
    prev   = latch_a;
    for (int i = 1; i <= 1200; i++) begin
      poll_a = (i == 20);
      tick();
      if (latch_a && !prev) rises++;
      if (valid_a) valids++;
      prev = latch_a;
    end
    poll_a = 1'b0;
    check("poll_extra_latch", rises,  0);
    check("poll_valid_cnt",   valids, 1);

    // POLL_NOW coinciding with a saturated poll counter: one frame only.
    enable_a = 1'b1;
    poll_a   = 1'b1;
    tick();
    poll_a   = 1'b0;
    check("both_latch", {31'b0, latch_a}, 32'd1);
    measure(300, f);
    check("both_valid_cnt", f.valid_cnt,     1);
    check("both_period",    f.next_latch_at, 200);

    // Asynchronous reset while PULSE is high.
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (pulse_a) begin
        n = i;
        break;
      end
    end
    check("pulse_seen", {31'b0, (n > 0)}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_latch",   {31'b0, latch_a}, 32'd0);
    check("arst_pulse",   {31'b0, pulse_a}, 32'd0);
    check("arst_busy",    {31'b0, busy_a},  32'd0);
    check("arst_buttons", buttons_a,        32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    cycles_to_latch(400, n);
    check("arst_latch_delay", n, 200);

    // 8-bit single-pad build.
    mon_sel = 1'b1;
    poll_b  = 1'b1;
    tick();
    poll_b  = 1'b0;
    check("b_latch", {31'b0, latch_b}, 32'd1);
    measure(300, f);
    check("b_latch_len",   f.latch_len,     8);
    check("b_pulse_rises", f.pulse_rises,   7);
    check("b_pulse_high",  f.pulse_high,    28);
    check("b_valid_at",    f.valid_at,      69);
    check("b_valid_cnt",   f.valid_cnt,     1);
    check("b_buttons",     f.buttons,       32'h0000_00A5);
    check("b_pressed",     f.pressed,       32'h0000_00A5);
    check("b_after",       f.after_events,  32'h0);
    check("b_no_relatch",  f.next_latch_at, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
